// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor
// 640x480 VGA raster generator that also requests pixels from two sprite readers.
// Sync, blank and colour are re-aligned to the sprite-reader reply latency.
// The composite priority is sprite 0, then sprite 1, then background, in RGB332.
// Optional feature macro: SPRITE_OVERLAP_EN. When it is defined, the block reports
// whether the two sprites overlapped during the previous frame.
module vga_sprite_compositor #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SPRITE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    input  logic       s0_visible,
    input  logic [7:0] s0_data,
    input  logic       s1_visible,
    input  logic [7:0] s1_data,
    input  logic [7:0] bg_color,
    output logic [7:0] vga_rgb,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       frame_start,
    output logic       overlap_flag
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic x_wrap;
    logic y_wrap;
    logic frame_wrap;
    logic active_raw;
    logic hs_raw;
    logic vs_raw;

    // One stage per clk of sprite-reader latency; the last stage lines up with sN_*.
    logic [SPRITE_LAT-1:0] act_sr;
    logic [SPRITE_LAT-1:0] hs_sr;
    logic [SPRITE_LAT-1:0] vs_sr;
    logic                  d_active;
    logic                  d_hs;
    logic                  d_vs;
    logic [7:0]            pix_rgb;

    assign x_wrap     = (px_x == H_LAST);
    assign y_wrap     = (px_y == V_LAST);
    assign frame_wrap = pix_en & x_wrap & y_wrap;

    assign active_raw = (px_x < H_ACT) && (px_y < V_ACT);
    assign hs_raw     = !((px_x >= HS_START) && (px_x <= HS_END));
    assign vs_raw     = !((px_y >= VS_START) && (px_y <= VS_END));

    assign d_active = act_sr[SPRITE_LAT-1];
    assign d_hs     = hs_sr[SPRITE_LAT-1];
    assign d_vs     = vs_sr[SPRITE_LAT-1];

    // Raster counters: advance on pixel ticks, x wraps each line, y wraps each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_x <= 10'd0;
            px_y <= 10'd0;
        end else if (pix_en) begin
            if (x_wrap) begin
                px_x <= 10'd0;
                px_y <= y_wrap ? 10'd0 : px_y + 10'd1;
            end else begin
                px_x <= px_x + 10'd1;
            end
        end
    end

    // Timing delay line shifts every clk, so a frozen raster settles after the full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_sr <= '0;
            hs_sr  <= '1;
            vs_sr  <= '1;
        end else begin
            act_sr[0] <= active_raw;
            hs_sr[0]  <= hs_raw;
            vs_sr[0]  <= vs_raw;
            for (int i = 1; i < SPRITE_LAT; i++) begin
                act_sr[i] <= act_sr[i-1];
                hs_sr[i]  <= hs_sr[i-1];
                vs_sr[i]  <= vs_sr[i-1];
            end
        end
    end

    // Priority mux; sprite replies are ignored outside the active area.
    always_comb begin
        pix_rgb = 8'h00;
        if (d_active) begin
            if (s0_visible) begin
                pix_rgb = s0_data;
            end else if (s1_visible) begin
                pix_rgb = s1_data;
            end else begin
                pix_rgb = bg_color;
            end
        end
    end

    // Pin registers: colour, sync and blank leave together; frame_start is undelayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rgb     <= 8'h00;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_rgb     <= pix_rgb;
            hsync       <= d_hs;
            vsync       <= d_vs;
            blank_n     <= d_active;
            frame_start <= frame_wrap;
        end
    end

`ifdef SPRITE_OVERLAP_EN
    logic overlap_seen;

    // Collect overlap over a frame and publish it at the wrap; the wrap is always in blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overlap_seen <= 1'b0;
            overlap_flag <= 1'b0;
        end else if (frame_wrap) begin
            overlap_flag <= overlap_seen;
            overlap_seen <= 1'b0;
        end else if (d_active && s0_visible && s1_visible) begin
            overlap_seen <= 1'b1;
        end
    end
`else
    assign overlap_flag = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Bench for vga_sprite_compositor: full-size instance for pixel/line behaviour,
// a shrunken-raster instance for frame-level behaviour (frame_start, vsync, overlap).
module tb_vga_sprite_compositor;

    localparam int L = 2;
`ifdef SPRITE_OVERLAP_EN
    localparam bit OV_ON = 1'b1;
`else
    localparam bit OV_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       s0v = 1'b0;
    logic       s1v = 1'b0;
    logic [7:0] s0d = 8'h00;
    logic [7:0] s1d = 8'h00;
    logic [7:0] bg = 8'h00;

    logic [9:0] px_x, px_y;
    logic [7:0] vga_rgb;
    logic       hsync, vsync, blank_n, frame_start, overlap_flag;

    logic [9:0] sx, sy;
    logic [7:0] s_rgb;
    logic       s_hs, s_vs, s_blank, s_fs, s_ov;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_sprite_compositor dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .px_x(px_x), .px_y(px_y),
        .s0_visible(s0v), .s0_data(s0d), .s1_visible(s1v), .s1_data(s1d),
        .bg_color(bg), .vga_rgb(vga_rgb), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .frame_start(frame_start), .overlap_flag(overlap_flag)
    );

    // 32 x 19 raster: 608 ticks per frame, vsync rows 14-15, hsync columns 20-25.
    vga_sprite_compositor #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SPRITE_LAT(L)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .px_x(sx), .px_y(sy),
        .s0_visible(s0v), .s0_data(s0d), .s1_visible(s1v), .s1_data(s1d),
        .bg_color(bg), .vga_rgb(s_rgb), .hsync(s_hs), .vsync(s_vs),
        .blank_n(s_blank), .frame_start(s_fs), .overlap_flag(s_ov)
    );

    // Reference model for the full-size instance: pixel index counts ticks since reset.
    int         m_ticks;
    bit         ha [1:L];
    bit         hh [1:L];
    bit         hv [1:L];
    logic [7:0] e_rgb;
    bit         e_blank, e_hs, e_vs, e_fs;

    function automatic bit f_active(int t);
        int x = t % 800;
        int y = (t / 800) % 525;
        return (x < 640) && (y < 480);
    endfunction

    function automatic bit f_hs(int t);
        int x = t % 800;
        return !(x >= 656 && x <= 751);
    endfunction

    function automatic bit f_vs(int t);
        int y = (t / 800) % 525;
        return !(y == 490 || y == 491);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ticks = 0;
            for (int j = 1; j <= L; j++) begin
                ha[j] = 1'b0;
                hh[j] = 1'b1;
                hv[j] = 1'b1;
            end
            e_rgb = 8'h00; e_blank = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
        end else begin
            e_blank = ha[L];
            e_hs    = hh[L];
            e_vs    = hv[L];
            if (!ha[L])  e_rgb = 8'h00;
            else if (s0v) e_rgb = s0d;
            else if (s1v) e_rgb = s1d;
            else          e_rgb = bg;
            e_fs = pix_en && ((m_ticks % 420000) == 419999);
            for (int j = L; j >= 2; j--) begin
                ha[j] = ha[j-1];
                hh[j] = hh[j-1];
                hv[j] = hv[j-1];
            end
            ha[1] = f_active(m_ticks);
            hh[1] = f_hs(m_ticks);
            hv[1] = f_vs(m_ticks);
            if (pix_en) m_ticks = m_ticks + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pix_en = 1'b0; s0v = 1'b0; s1v = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        pix_en = 1'b1;
        repeat (137) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (px_x !== 10'd0 || px_y !== 10'd0) begin failures++;
            $display("FAIL reset_px got=(%0d,%0d) exp=(0,0)", px_x, px_y); end
        checks++; if ({hsync, vsync, blank_n} !== 3'b110) begin failures++;
            $display("FAIL reset_sync got hs/vs/blank=%b exp=110", {hsync, vsync, blank_n}); end
        checks++; if (vga_rgb !== 8'h00 || frame_start !== 1'b0 || overlap_flag !== 1'b0) begin failures++;
            $display("FAIL reset_rgb got rgb=%h fs=%b ov=%b exp 00/0/0", vga_rgb, frame_start, overlap_flag); end
        checks++; if (sx !== 10'd0 || s_rgb !== 8'h00 || s_ov !== 1'b0) begin failures++;
            $display("FAIL reset_small got x=%0d rgb=%h ov=%b exp 0/00/0", sx, s_rgb, s_ov); end
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (px_x !== 10'd0 || px_y !== 10'd0 || hsync !== 1'b1 || blank_n !== 1'b0) begin failures++;
            $display("FAIL reset_release got=(%0d,%0d) hs=%b blank=%b exp=(0,0) 1 0", px_x, px_y, hsync, blank_n); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++; if (px_x !== 10'(m_ticks % 800) || px_y !== 10'((m_ticks / 800) % 525)) begin failures++;
                $display("FAIL rand_px n=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, px_x, px_y, m_ticks % 800, (m_ticks / 800) % 525); end
            checks++; if (vga_rgb !== e_rgb) begin failures++;
                $display("FAIL rand_rgb n=%0d got=%h exp=%h", n, vga_rgb, e_rgb); end
            checks++; if ({blank_n, hsync, vsync, frame_start} !== {e_blank, e_hs, e_vs, e_fs}) begin failures++;
                $display("FAIL rand_timing n=%0d got blank/hs/vs/fs=%b exp=%b", n,
                         {blank_n, hsync, vsync, frame_start}, {e_blank, e_hs, e_vs, e_fs}); end
            checks++; if (overlap_flag !== 1'b0) begin failures++;
                $display("FAIL rand_overlap n=%0d got=%b exp=0", n, overlap_flag); end
            pix_en = ($urandom_range(0, 3) != 0);
            s0v = $urandom_range(0, 1) == 1;
            s1v = $urandom_range(0, 1) == 1;
            s0d = 8'($urandom);
            s1d = 8'($urandom);
            bg  = 8'($urandom);
        end
    endtask

    task automatic test_timing();
        int ticks = 0;
        int first656 = -1;
        int firstlow = -1;
        int lows = 0;
        bit line_seen = 1'b0;
        do_reset();
        for (int i = 0; i < 1620; i++) begin
            @(negedge clk);
            if (ticks == 656 && first656 < 0) first656 = i;
            if (hsync === 1'b0) begin
                lows++;
                if (firstlow < 0) firstlow = i;
            end
            if (ticks == 800 && !line_seen) begin
                line_seen = 1'b1;
                checks++; if (px_x !== 10'd0 || px_y !== 10'd1) begin failures++;
                    $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", px_x, px_y); end
            end
            pix_en = (i % 2 == 0);
            if (pix_en) ticks++;
        end
        checks++; if (firstlow - first656 !== 3) begin failures++;
            $display("FAIL hsync_latency got=%0d exp=3", firstlow - first656); end
        checks++; if (lows !== 192) begin failures++;
            $display("FAIL hsync_width got=%0d clk exp=192 (96 ticks)", lows); end
    endtask

    // Leaves the main raster frozen at (10,10).
    task automatic test_latency();
        do_reset();
        bg = 8'h4A; s0v = 1'b0; s1v = 1'b0;
        for (int i = 0; i < 8010; i++) begin
            @(negedge clk);
            pix_en = 1'b1;
        end
        @(negedge clk);
        pix_en = 1'b0;
        checks++; if (px_x !== 10'd10 || px_y !== 10'd10) begin failures++;
            $display("FAIL lat_coord got=(%0d,%0d) exp=(10,10)", px_x, px_y); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (vga_rgb !== 8'h4A) begin failures++;
            $display("FAIL lat_pre got=%h exp=4a", vga_rgb); end
        s0v = 1'b1; s0d = 8'hE0;
        @(negedge clk);
        checks++; if (vga_rgb !== 8'hE0 || blank_n !== 1'b1) begin failures++;
            $display("FAIL lat_hit got rgb=%h blank=%b exp=e0 1", vga_rgb, blank_n); end
        s0v = 1'b0;
        @(negedge clk);
        checks++; if (vga_rgb !== 8'h4A) begin failures++;
            $display("FAIL lat_post got=%h exp=4a", vga_rgb); end
    endtask

    task automatic test_priority();
        logic [7:0] exp_c;
        logic [40:0] tbl [3];
        tbl[0] = {1'b1, 8'h1C, 1'b1, 8'h03, 8'h25, 8'h1C, 7'd0};
        tbl[1] = {1'b0, 8'h1C, 1'b1, 8'h03, 8'h25, 8'h03, 7'd0};
        tbl[2] = {1'b0, 8'h1C, 1'b0, 8'h03, 8'h25, 8'h25, 7'd0};
        for (int k = 0; k < 3; k++) begin
            {s0v, s0d, s1v, s1d, bg} = tbl[k][40:15];
            exp_c = tbl[k][14:7];
            @(negedge clk);
            checks++; if (vga_rgb !== exp_c) begin failures++;
                $display("FAIL prio_case%0d got=%h exp=%h", k, vga_rgb, exp_c); end
        end
        for (int k = 0; k < 8; k++) begin
            s0v = $urandom_range(0, 1) == 1; s1v = $urandom_range(0, 1) == 1;
            s0d = 8'($urandom); s1d = 8'($urandom); bg = 8'($urandom);
            exp_c = s0v ? s0d : (s1v ? s1d : bg);
            @(negedge clk);
            checks++; if (vga_rgb !== exp_c) begin failures++;
                $display("FAIL prio_rand%0d got=%h exp=%h", k, vga_rgb, exp_c); end
        end
    endtask

    task automatic test_blank();
        s0v = 1'b0; s1v = 1'b0;
        for (int i = 0; i < 690; i++) begin
            @(negedge clk);
            pix_en = 1'b1;
        end
        @(negedge clk);
        pix_en = 1'b0;
        s0v = 1'b1; s0d = 8'hFF; s1v = 1'b1; s1d = 8'h77; bg = 8'h55;
        repeat (4) @(negedge clk);
        checks++; if (px_x !== 10'd700 || px_y !== 10'd10) begin failures++;
            $display("FAIL blank_coord got=(%0d,%0d) exp=(700,10)", px_x, px_y); end
        checks++; if (vga_rgb !== 8'h00 || blank_n !== 1'b0 || hsync !== 1'b0) begin failures++;
            $display("FAIL blank_out got rgb=%h blank=%b hs=%b exp=00 0 0", vga_rgb, blank_n, hsync); end
        s0v = 1'b0; s1v = 1'b0;
    endtask

    task automatic test_frame();
        int ticks = 0;
        int fs_count = 0;
        int vs_lows = 0;
        int vs_first = -1;
        do_reset();
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (s_fs === 1'b1) fs_count++;
            if (ticks < 608 && s_vs === 1'b0) begin
                vs_lows++;
                if (vs_first < 0) vs_first = ticks;
            end
            if (ticks == 608 || ticks == 1216) begin
                checks++; if (s_fs !== 1'b1 || sx !== 10'd0 || sy !== 10'd0) begin failures++;
                    $display("FAIL frame_start t=%0d got fs=%b (%0d,%0d) exp 1 (0,0)", ticks, s_fs, sx, sy); end
            end
            if (ticks == 608) begin
                checks++; if (s_blank !== 1'b0 || s_rgb !== 8'h00 || s_hs !== 1'b1) begin failures++;
                    $display("FAIL frame_wrap_blank got blank=%b rgb=%h hs=%b exp 0 00 1", s_blank, s_rgb, s_hs); end
            end
            pix_en = 1'b1;
            ticks++;
        end
        checks++; if (fs_count !== 2) begin failures++;
            $display("FAIL frame_count got=%0d exp=2", fs_count); end
        checks++; if (vs_lows !== 64 || vs_first !== 451) begin failures++;
            $display("FAIL vsync got lows=%0d first=%0d exp=64 451", vs_lows, vs_first); end
    endtask

    task automatic test_overlap();
        int ticks = 0;
        do_reset();
        s0d = 8'h1C; s1d = 8'h03;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (ticks == 300 || ticks == 607) begin
                checks++; if (s_ov !== 1'b0) begin failures++;
                    $display("FAIL ovl_frameN t=%0d got=%b exp=0", ticks, s_ov); end
            end
            if (ticks == 608 || ticks == 1215) begin
                checks++; if (s_ov !== OV_ON) begin failures++;
                    $display("FAIL ovl_frameN1 t=%0d got=%b exp=%b", ticks, s_ov, OV_ON); end
            end
            if (ticks == 1216 || ticks == 1290) begin
                checks++; if (s_ov !== 1'b0) begin failures++;
                    $display("FAIL ovl_frameN2 t=%0d got=%b exp=0", ticks, s_ov); end
            end
            pix_en = 1'b1;
            s0v = (ticks >= 67 && ticks <= 72);
            s1v = s0v;
            ticks++;
        end
        s0v = 1'b0; s1v = 1'b0;
    endtask

    initial begin
        test_reset();
        test_random();
        test_timing();
        test_latency();
        test_priority();
        test_blank();
        test_frame();
        test_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
